tetris_board_dp: RTL and testbench
==================================

// Module: tetris_board_dp
// PURPOSE
//  Parametrised single-clock Tetris datapath. It holds the BOARD_W x BOARD_H committed board and
//  one active 2x2 piece, and runs the GEN/MOVE/LAND/CLEAR/NEWBOARD/OVER sequence.
//  Pieces arrive from the external RNG through a valid/ready handshake. The block clears multiple
//  rows, supports hard drop, counts lines and detects game over. It sits between rng and the display/score logic.
// PARAMETERS
//  BOARD_W  4  board columns (>=2)
//  BOARD_H  8  board rows (>=2); row 0 = top
//  SCORE_W  8  lines_cleared counter width
// PORTS
//  clka           in   1          system clock; all state updates on posedge
//  restart        in   1          synchronous active-high reset
//  piece_valid    in   1          RNG offers a piece
//  piece_ready    out  1          =1 iff state==GEN
//  piece_shape    in   4          2x2 mask: b0=TL b1=TR b2=BL b3=BR
//  move           in   2          00 none, 01 left, 10 right, 11 hard drop
//  tick           in   1          gravity strobe, 1 cycle wide
//  board_out      out  W*H        committed board; row r = [r*W +: W], bit c = column c
//  piece_row      out  clog2(H)   active piece top row
//  piece_col      out  clog2(W)   active piece left column
//  piece_mask     out  4          active piece mask (0 when no piece is active)
//  lines_cleared  out  SCORE_W    saturating count of cleared rows
//  state_out      out  3          current FSM state
//  done           out  1          1-cycle pulse in NEWBOARD
//  game_over      out  1          held high in OVER
// BEHAVIOUR
//  - Reset (restart=1 at posedge, overrides everything, including mid-operation):
//    state=GEN, board=0, row=col=0, mask=0, drop flag=0, lines=0, done=0, game_over=0.
//  - fits(mask,r,c): r<=H-2, c<=W-2, and no set mask bit overlaps a set board bit.
//  - GEN: on piece_valid & piece_ready, load the mask (4'b0000 is replaced by 4'b1111).
//    Set row=0, col=(W-2)/2.
//    If !fits -> OVER, else -> MOVE. The transition takes 1 cycle.
//  - MOVE, drop flag=0:
//    - move=01/10: shift col -/+1 if fits, else ignore; walls are hard limits with no wrap.
//    - Then, same cycle, if tick: row+1 if fits at the post-shift col, else -> LAND.
//    - move=11: set the drop flag. Shift and tick are ignored that cycle.
//  - MOVE, drop flag=1: row+1 every cycle while it fits, else -> LAND and clear the flag.
//    move and tick are ignored.
//  - LAND: OR the piece into the board, set mask=0 -> CLEAR.
//  - CLEAR: each cycle, find the lowest full row f (all W bits set).
//    If found: shift rows 0..f-1 down one, row 0 becomes 0, lines+1 (saturates at 2^SCORE_W-1), stay in CLEAR.
//    If none: -> NEWBOARD. k full rows take k+1 cycles in CLEAR.
//  - NEWBOARD: done=1 for exactly this cycle -> GEN.
//  - OVER: board is frozen, game_over=1, piece_ready=0. Exit only via restart.
//  - move, tick and piece_valid have no effect outside the states named above.
// STRUCTURE
//  - tetris_pkg: state encoding (GEN=0 MOVE=1 LAND=2 CLEAR=3 NEWBOARD=4 OVER=5), move codes,
//    mask bit layout, fits() and place() functions.
//  - Sub-module tetris_row_clear: combinational. Lowest-full-row detect plus compacted board
//    output and a found flag.
// TESTING (W=4, H=8)
//  1. Pulse restart -> board_out=0, state GEN, piece_ready=1, lines=0, done=0, game_over=0.
//  2. Spawn 4'b1111 (col 1), 6 ticks -> row 6.
//     7th tick -> LAND, then board_out=32'h6600_0000.
//     One CLEAR cycle, then one done pulse, then GEN.
//  3. Spawn; move=01 x3 -> col 0 (stays 0); move=10 x4 -> col 2 (stays 2).
//  4. Square at col 0 via left + hard drop, then a second at col 2 via right + hard drop.
//     Rows 6,7 become full -> 2 clearing cycles, board_out=0, lines=2, done pulse.
//  5. Stack 4 squares at col 1 (board=32'h6666_6666). 5th spawn collides -> OVER.
//     game_over=1, piece_ready=0, board unchanged. restart -> GEN.
//  6. Assert restart during a hard drop -> reset values next cycle.
//     With SCORE_W=2, clear 4 rows -> lines saturates at 3.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared Tetris datapath definitions: FSM encoding, move codes, 2x2 mask layout
// and the fits/place helpers over a flattened row-major board (bit = r*W + c).
package tetris_pkg;

  typedef enum logic [2:0] {
    ST_GEN      = 3'd0,
    ST_MOVE     = 3'd1,
    ST_LAND     = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_NEWBOARD = 3'd4,
    ST_OVER     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MV_NONE  = 2'b00,
    MV_LEFT  = 2'b01,
    MV_RIGHT = 2'b10,
    MV_DROP  = 2'b11
  } move_t;

  localparam int unsigned MASK_TL = 0;
  localparam int unsigned MASK_TR = 1;
  localparam int unsigned MASK_BL = 2;
  localparam int unsigned MASK_BR = 3;

  // Helpers work on a board zero-extended to MAX_CELLS, so W*H must not exceed it.
  localparam int unsigned MAX_CELLS  = 1024;
  localparam int unsigned CELL_IDX_W = 10;
  typedef logic [MAX_CELLS-1:0] cells_t;

  function automatic int unsigned row_off(int unsigned k);
    return (k == MASK_BL || k == MASK_BR) ? 1 : 0;
  endfunction

  function automatic int unsigned col_off(int unsigned k);
    return (k == MASK_TR || k == MASK_BR) ? 1 : 0;
  endfunction

  function automatic logic [CELL_IDX_W-1:0] cell_idx(int unsigned r, int unsigned c,
                                                     int unsigned w);
    return CELL_IDX_W'(r * w + c);
  endfunction

  function automatic logic fits(logic [3:0] mask, int unsigned r, int unsigned c,
                                int unsigned w, int unsigned h, cells_t board);
    logic ok;
    ok = (r <= h - 2) && (c <= w - 2);
    for (int unsigned k = 0; k < 4; k++)
      if (mask[2'(k)] && board[cell_idx(r + row_off(k), c + col_off(k), w)]) ok = 1'b0;
    return ok;
  endfunction

  function automatic cells_t place(logic [3:0] mask, int unsigned r, int unsigned c,
                                   int unsigned w, cells_t board);
    cells_t b;
    b = board;
    for (int unsigned k = 0; k < 4; k++)
      if (mask[2'(k)]) b[cell_idx(r + row_off(k), c + col_off(k), w)] = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/tetris_board_dp_row_clear.sv
// Combinational lowest-full-row finder; removes that row and shifts everything above it down.
module tetris_row_clear #(
  parameter int unsigned BOARD_W = 4,
  parameter int unsigned BOARD_H = 8
) (
  input  logic [BOARD_W*BOARD_H-1:0] board,
  output logic                       found,
  output logic [BOARD_W*BOARD_H-1:0] compacted
);

  logic [31:0] full_row;

  always_comb begin
    found    = 1'b0;
    full_row = '0;
    // Ascending scan, so the last hit is the lowest (highest-numbered) full row.
    for (int unsigned r = 0; r < BOARD_H; r++)
      if (&board[r*BOARD_W +: BOARD_W]) begin
        found    = 1'b1;
        full_row = r;
      end

    compacted = board;
    if (found) begin
      compacted[BOARD_W-1:0] = '0;
      for (int unsigned r = 1; r < BOARD_H; r++)
        if (r <= full_row) compacted[r*BOARD_W +: BOARD_W] = board[(r-1)*BOARD_W +: BOARD_W];
    end
  end

endmodule

// File: rtl/tetris_board_dp.sv
// Single-clock Tetris datapath: committed board, one active 2x2 piece, line clearing
// and game-over detection, fed by an RNG over a valid/ready handshake.
module tetris_board_dp
  import tetris_pkg::*;
#(
  parameter int unsigned BOARD_W = 4,
  parameter int unsigned BOARD_H = 8,
  parameter int unsigned SCORE_W = 8
) (
  input  logic                       clka,
  input  logic                       restart,
  input  logic                       piece_valid,
  output logic                       piece_ready,
  input  logic [3:0]                 piece_shape,
  input  logic [1:0]                 move,
  input  logic                       tick,
  output logic [BOARD_W*BOARD_H-1:0] board_out,
  output logic [$clog2(BOARD_H)-1:0] piece_row,
  output logic [$clog2(BOARD_W)-1:0] piece_col,
  output logic [3:0]                 piece_mask,
  output logic [SCORE_W-1:0]         lines_cleared,
  output logic [2:0]                 state_out,
  output logic                       done,
  output logic                       game_over
);

  localparam int unsigned CELLS     = BOARD_W * BOARD_H;
  localparam int unsigned RW        = $clog2(BOARD_H);
  localparam int unsigned CW        = $clog2(BOARD_W);
  localparam int unsigned SPAWN_COL = (BOARD_W - 2) / 2;

  state_t             state, state_nxt;
  logic [CELLS-1:0]   board, board_nxt, compacted;
  logic [RW-1:0]      row, row_nxt;
  logic [CW-1:0]      col, col_nxt;
  logic [3:0]         mask, mask_nxt, shape;
  logic               drop, drop_nxt, found;
  logic [SCORE_W-1:0] lines, lines_nxt;
  logic [31:0]        r_cur, c_cur, c_new;
  cells_t             board_ext;

  tetris_row_clear #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H)) u_row_clear (
    .board     (board),
    .found     (found),
    .compacted (compacted)
  );

  always_ff @(posedge clka) begin
    if (restart) begin
      state <= ST_GEN;
      board <= '0;
      row   <= '0;
      col   <= '0;
      mask  <= '0;
      drop  <= 1'b0;
      lines <= '0;
    end else begin
      state <= state_nxt;
      board <= board_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      mask  <= mask_nxt;
      drop  <= drop_nxt;
      lines <= lines_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    board_nxt = board;
    row_nxt   = row;
    col_nxt   = col;
    mask_nxt  = mask;
    drop_nxt  = drop;
    lines_nxt = lines;
    r_cur     = 32'(row);
    c_cur     = 32'(col);
    c_new     = c_cur;
    board_ext = cells_t'(board);
    shape     = (piece_shape == 4'b0000) ? 4'b1111 : piece_shape;

    unique case (state)
      ST_GEN: begin
        if (piece_valid) begin
          row_nxt = '0;
          col_nxt = CW'(SPAWN_COL);
          if (fits(shape, 0, SPAWN_COL, BOARD_W, BOARD_H, board_ext)) begin
            mask_nxt  = shape;
            state_nxt = ST_MOVE;
          end else begin
            mask_nxt  = '0;
            state_nxt = ST_OVER;
          end
        end
      end
      ST_MOVE: begin
        if (drop) begin
          if (fits(mask, r_cur + 1, c_cur, BOARD_W, BOARD_H, board_ext)) row_nxt = row + 1'b1;
          else begin
            drop_nxt  = 1'b0;
            state_nxt = ST_LAND;
          end
        end else if (move == MV_DROP) begin
          drop_nxt = 1'b1;
        end else begin
          // Gravity is tested at the post-shift column within the same cycle.
          if (move == MV_LEFT && c_cur > 0 &&
              fits(mask, r_cur, c_cur - 1, BOARD_W, BOARD_H, board_ext))
            c_new = c_cur - 1;
          else if (move == MV_RIGHT &&
                   fits(mask, r_cur, c_cur + 1, BOARD_W, BOARD_H, board_ext))
            c_new = c_cur + 1;
          col_nxt = CW'(c_new);
          if (tick) begin
            if (fits(mask, r_cur + 1, c_new, BOARD_W, BOARD_H, board_ext)) row_nxt = row + 1'b1;
            else state_nxt = ST_LAND;
          end
        end
      end
      ST_LAND: begin
        board_nxt = CELLS'(place(mask, r_cur, c_cur, BOARD_W, board_ext));
        mask_nxt  = '0;
        state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (found) begin
          board_nxt = compacted;
          if (lines != '1) lines_nxt = lines + 1'b1;
        end else begin
          state_nxt = ST_NEWBOARD;
        end
      end
      ST_NEWBOARD: state_nxt = ST_GEN;
      ST_OVER:     state_nxt = ST_OVER;
      default:     state_nxt = ST_GEN;
    endcase
  end

  assign board_out     = board;
  assign piece_row     = row;
  assign piece_col     = col;
  assign piece_mask    = mask;
  assign lines_cleared = lines;
  assign state_out     = state;
  assign piece_ready   = (state == ST_GEN);
  assign done          = (state == ST_NEWBOARD);
  assign game_over     = (state == ST_OVER);

endmodule

// File: tb/tb_tetris_board_dp.sv
// Bench for tetris_board_dp: a 2-D array game model checked every cycle, directed
// scenarios with literal expectations, then randomized play; a SCORE_W=2 copy checks saturation.
module tb_tetris_board_dp;

  localparam int W = 4;
  localparam int H = 8;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic       restart = 1'b1, piece_valid = 1'b0, tick = 1'b0;
  logic [3:0] piece_shape = 4'h0;
  logic [1:0] move = 2'b00;

  logic           piece_ready, done, game_over;
  logic [W*H-1:0] board_out;
  logic [2:0]     piece_row, state_out;
  logic [1:0]     piece_col;
  logic [3:0]     piece_mask;
  logic [7:0]     lines_cleared;

  logic           ready_s, done_s, over_s;
  logic [W*H-1:0] board_s;
  logic [2:0]     row_s, state_s;
  logic [1:0]     col_s, lines_s;
  logic [3:0]     mask_s;

  tetris_board_dp #(.BOARD_W(W), .BOARD_H(H), .SCORE_W(8)) dut (
    .clka(clka), .restart(restart), .piece_valid(piece_valid), .piece_ready(piece_ready),
    .piece_shape(piece_shape), .move(move), .tick(tick), .board_out(board_out),
    .piece_row(piece_row), .piece_col(piece_col), .piece_mask(piece_mask),
    .lines_cleared(lines_cleared), .state_out(state_out), .done(done), .game_over(game_over));

  tetris_board_dp #(.BOARD_W(W), .BOARD_H(H), .SCORE_W(2)) dut_sat (
    .clka(clka), .restart(restart), .piece_valid(piece_valid), .piece_ready(ready_s),
    .piece_shape(piece_shape), .move(move), .tick(tick), .board_out(board_s),
    .piece_row(row_s), .piece_col(col_s), .piece_mask(mask_s),
    .lines_cleared(lines_s), .state_out(state_s), .done(done_s), .game_over(over_s));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Game model: board as a grid, piece as (row, col, mask); state numbers are the external codes.
  bit         mb[H][W];
  int         m_state = 0, m_row = 0, m_col = 0, m_lines = 0, m_full;
  bit         m_drop = 0, m_valid = 0, m_isfull;
  logic [3:0] m_mask = 0, m_new;

  function automatic bit m_fits(logic [3:0] mk, int r, int c);
    if (r > H - 2 || c < 0 || c > W - 2) return 0;
    for (int k = 0; k < 4; k++)
      if (mk[k] && mb[r + k / 2][c + k % 2]) return 0;
    return 1;
  endfunction

  function automatic logic [W*H-1:0] flat();
    logic [W*H-1:0] v;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) v[r*W + c] = mb[r][c];
    return v;
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clka) begin
    if (restart) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) mb[r][c] = 0;
      m_state = 0; m_row = 0; m_col = 0; m_mask = 0; m_drop = 0; m_lines = 0; m_valid = 1;
    end else begin
      case (m_state)
        0: if (piece_valid) begin
          m_new = (piece_shape == 0) ? 4'hF : piece_shape;
          m_row = 0;
          m_col = (W - 2) / 2;
          if (m_fits(m_new, 0, m_col)) begin m_mask = m_new; m_state = 1; end
          else begin m_mask = 0; m_state = 5; end
        end
        1: if (m_drop) begin
          if (m_fits(m_mask, m_row + 1, m_col)) m_row++;
          else begin m_drop = 0; m_state = 2; end
        end else if (move == 2'b11) begin
          m_drop = 1;
        end else begin
          if (move == 2'b01 && m_fits(m_mask, m_row, m_col - 1)) m_col--;
          else if (move == 2'b10 && m_fits(m_mask, m_row, m_col + 1)) m_col++;
          if (tick) begin
            if (m_fits(m_mask, m_row + 1, m_col)) m_row++;
            else m_state = 2;
          end
        end
        2: begin
          for (int k = 0; k < 4; k++)
            if (m_mask[k]) mb[m_row + k / 2][m_col + k % 2] = 1;
          m_mask = 0;
          m_state = 3;
        end
        3: begin
          m_full = -1;
          for (int r = H - 1; r >= 0; r--) begin
            m_isfull = 1;
            for (int c = 0; c < W; c++) if (!mb[r][c]) m_isfull = 0;
            if (m_isfull && m_full < 0) m_full = r;
          end
          if (m_full >= 0) begin
            for (int r = m_full; r > 0; r--) mb[r] = mb[r - 1];
            for (int c = 0; c < W; c++) mb[0][c] = 0;
            m_lines++;
          end else m_state = 4;
        end
        4: m_state = 0;
        default: ;
      endcase
    end
  end

  always @(negedge clka) begin
    if (m_valid) begin
      chk("board", board_out, flat());
      chk("row", piece_row, 64'(m_row));
      chk("col", piece_col, 64'(m_col));
      chk("mask", piece_mask, m_mask);
      chk("state", state_out, 64'(m_state));
      chk("ready", piece_ready, m_state == 0);
      chk("done", done, m_state == 4);
      chk("game_over", game_over, m_state == 5);
      chk("lines", lines_cleared, 64'(sat(m_lines, 255)));
      chk("sat_lines", lines_s, 64'(sat(m_lines, 3)));
      chk("sat_board", board_s, flat());
      chk("sat_state", state_s, 64'(m_state));
    end
  end

  task automatic step(input logic rs, input logic pv, input logic [3:0] sh,
                      input logic [1:0] mv, input logic tk);
    restart = rs; piece_valid = pv; piece_shape = sh; move = mv; tick = tk;
    @(posedge clka);
    @(negedge clka);
  endtask

  task automatic idle();
    step(0, 0, 4'h0, 2'b00, 0);
  endtask

  task automatic drop_at(input logic [1:0] dir);
    step(0, 1, 4'hF, 2'b00, 0);
    if (dir != 2'b00) step(0, 0, 4'h0, dir, 0);
    step(0, 0, 4'h0, 2'b11, 0);
  endtask

  task automatic run_to_gen(output int clear_cyc);
    int n = 0;
    clear_cyc = 0;
    while (state_out != 3'd0 && n < 60) begin
      idle();
      n++;
      if (state_out == 3'd3) clear_cyc++;
    end
    chk("gen_timeout", state_out, 0);
  endtask

  int cc;
  int r10;
  logic [W*H-1:0] frozen;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clka);
    step(1, 0, 4'h0, 2'b00, 0);
    chk("rst_board", board_out, 0);
    chk("rst_state", state_out, 0);
    chk("rst_ready", piece_ready, 1);
    chk("rst_lines", lines_cleared, 0);
    chk("rst_done", done, 0);
    chk("rst_over", game_over, 0);

    step(0, 1, 4'hF, 2'b00, 0);
    chk("spawn_col", piece_col, 1);
    chk("spawn_state", state_out, 1);
    repeat (6) step(0, 0, 4'h0, 2'b00, 1);
    chk("six_ticks_row", piece_row, 6);
    step(0, 0, 4'h0, 2'b00, 1);
    chk("land_state", state_out, 2);
    idle();
    chk("landed_board", board_out, 32'h6600_0000);
    chk("model_landed_board", flat(), 32'h6600_0000);
    chk("clear_state", state_out, 3);
    idle();
    chk("done_pulse", done, 1);
    idle();
    chk("done_low", done, 0);
    chk("back_gen", state_out, 0);

    step(0, 1, 4'h0, 2'b00, 0);
    chk("zero_shape_mask", piece_mask, 4'hF);
    repeat (3) step(0, 0, 4'h0, 2'b01, 0);
    chk("left_wall", piece_col, 0);
    repeat (4) step(0, 0, 4'h0, 2'b10, 0);
    chk("right_wall", piece_col, 2);

    step(1, 0, 4'h0, 2'b00, 0);
    drop_at(2'b01); run_to_gen(cc);
    chk("single_clear_cycles", cc, 1);
    drop_at(2'b10); run_to_gen(cc);
    chk("double_clear_cycles", cc, 3);
    chk("cleared_board", board_out, 0);
    chk("lines_two", lines_cleared, 2);

    step(1, 0, 4'h0, 2'b00, 0);
    repeat (4) begin drop_at(2'b00); run_to_gen(cc); end
    chk("stack_board", board_out, 32'h6666_6666);
    chk("model_stack_board", flat(), 32'h6666_6666);
    step(0, 1, 4'hF, 2'b00, 0);
    chk("over_state", state_out, 5);
    chk("over_flag", game_over, 1);
    chk("over_ready", piece_ready, 0);
    frozen = board_out;
    repeat (5) step(0, 1, 4'($urandom), 2'($urandom), 1'($urandom));
    chk("over_frozen", board_out, frozen);
    chk("over_sticky", state_out, 5);
    step(1, 0, 4'h0, 2'b00, 0);
    chk("over_restart", state_out, 0);

    drop_at(2'b00);
    idle(); idle();
    step(1, 0, 4'h0, 2'b00, 0);
    chk("mid_drop_state", state_out, 0);
    chk("mid_drop_row", piece_row, 0);
    chk("mid_drop_mask", piece_mask, 0);
    repeat (2) begin
      drop_at(2'b01); run_to_gen(cc);
      drop_at(2'b10); run_to_gen(cc);
    end
    chk("lines_four", lines_cleared, 4);
    chk("lines_saturated", lines_s, 3);

    repeat (3000) begin
      r10 = $urandom_range(0, 9);
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0, 4'($urandom),
           (r10 < 5) ? 2'b00 : (r10 < 7) ? 2'b01 : (r10 < 9) ? 2'b10 : 2'b11,
           $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
